// File: rtl/gmii_router.sv
// GMII ingress router: delays the receive stream by 16 cycles while the destination
// MAC is looked up, then replicates each frame onto the egress ports picked by the lookup.
module gmii_router #(
  parameter int unsigned PORT_NUMBER       = 4,
  parameter int unsigned THIS_PORT_ROUTING = 0,
  parameter int unsigned TABLE_DEPTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [TABLE_DEPTH*48-1:0]                 table_mac,
  input  logic [TABLE_DEPTH*$clog2(PORT_NUMBER)-1:0] table_port,
  input  logic [TABLE_DEPTH-1:0]                    table_valid,
  input  logic [7:0]                                rxd_in,
  input  logic                                      rx_dv_in,
  input  logic                                      rx_err_in,
  output logic [PORT_NUMBER*8-1:0]                  rxd_out,
  output logic [PORT_NUMBER-1:0]                    rx_dv_out,
  output logic [PORT_NUMBER-1:0]                    rx_err_out
);

  localparam int unsigned PORT_W   = $clog2(PORT_NUMBER);
  localparam int unsigned MAC_W    = 48;
  // 15 line stages plus the output register give 16 cycles of latency
  localparam int unsigned LINE_LEN = 15;

  localparam logic [3:0] CNT_MAX      = 4'd15;
  localparam logic [3:0] MAC_FIRST    = 4'd8;
  localparam logic [3:0] MAC_LAST     = 4'd13;

  localparam logic [PORT_W:0]        PORT_LIMIT = (PORT_W+1)'(PORT_NUMBER);
  localparam logic [PORT_W-1:0]      THIS_IDX   = PORT_W'(THIS_PORT_ROUTING);
  localparam logic [PORT_NUMBER-1:0] THIS_BIT   = PORT_NUMBER'(1) << THIS_PORT_ROUTING;
  localparam logic [PORT_NUMBER-1:0] ALL_BUT    = ~THIS_BIT;

  typedef struct packed {
    logic [7:0] data;
    logic       dv;
    logic       err;
  } gmii_beat_t;

  gmii_beat_t                 line_q [LINE_LEN];
  gmii_beat_t                 in_beat_c;
  gmii_beat_t                 dly_beat_c;

  logic                       rx_dv_prev_q;
  logic                       in_frame_q;
  logic [3:0]                 byte_cnt_q;
  logic [MAC_W-1:0]           dst_mac_q;
  logic                       lookup_q;

  logic                       rise_c;
  logic                       count_en_c;
  logic [3:0]                 byte_idx_c;

  logic                       hit_c;
  logic [PORT_W-1:0]          hit_port_c;
  logic [PORT_NUMBER-1:0]     decision_c;

  logic [PORT_NUMBER-1:0]     pending_q;
  logic [PORT_NUMBER-1:0]     active_q;
  logic                       dly_dv_prev_q;
  logic                       dly_rise_c;
  logic [PORT_NUMBER-1:0]     mask_sel_c;
  logic [PORT_NUMBER-1:0]     out_mask_c;

  always_comb begin
    in_beat_c      = '0;
    in_beat_c.data = rxd_in;
    in_beat_c.dv   = rx_dv_in;
    in_beat_c.err  = rx_err_in;
  end

  // Fixed-latency delay line carrying the raw receive triple
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LINE_LEN); i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= in_beat_c;
      for (int i = 1; i < int'(LINE_LEN); i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dly_beat_c = line_q[LINE_LEN-1];

  // Frame tracking on the undelayed stream; a frame only counts once its dv edge is seen
  always_comb begin
    rise_c     = rx_dv_in & ~rx_dv_prev_q;
    count_en_c = rise_c | (rx_dv_in & in_frame_q);
    byte_idx_c = rise_c ? 4'd0 : byte_cnt_q;
  end

  // dv history resets high so a frame already in flight at reset release is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_dv_prev_q <= 1'b1;
      in_frame_q   <= 1'b0;
      byte_cnt_q   <= 4'd0;
    end else begin
      rx_dv_prev_q <= rx_dv_in;
      if (rise_c) begin
        in_frame_q <= 1'b1;
      end else if (!rx_dv_in) begin
        in_frame_q <= 1'b0;
      end
      if (rise_c) begin
        byte_cnt_q <= 4'd1;
      end else if (count_en_c && byte_cnt_q != CNT_MAX) begin
        byte_cnt_q <= byte_cnt_q + 4'd1;
      end
    end
  end

  // Destination MAC shifts in MSB first; the lookup fires the cycle after its last byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_mac_q <= '0;
      lookup_q  <= 1'b0;
    end else begin
      if (count_en_c && byte_idx_c >= MAC_FIRST && byte_idx_c <= MAC_LAST) begin
        dst_mac_q <= {dst_mac_q[MAC_W-9:0], rxd_in};
      end
      lookup_q <= count_en_c && (byte_idx_c == MAC_LAST);
    end
  end

  // Parallel compare; scanning downwards leaves the lowest matching index
  always_comb begin
    hit_c      = 1'b0;
    hit_port_c = '0;
    for (int i = int'(TABLE_DEPTH) - 1; i >= 0; i--) begin
      if (table_valid[i] && (table_mac[i*MAC_W +: MAC_W] == dst_mac_q)) begin
        hit_c      = 1'b1;
        hit_port_c = table_port[i*PORT_W +: PORT_W];
      end
    end
  end

  // Group bit, misses and out-of-range ports all flood
  always_comb begin
    decision_c = ALL_BUT;
    if (!dst_mac_q[MAC_W-8] && hit_c && ({1'b0, hit_port_c} < PORT_LIMIT)) begin
      if (hit_port_c == THIS_IDX) begin
        decision_c = '0;
      end else begin
        decision_c = PORT_NUMBER'(1) << hit_port_c;
      end
    end
  end

  // Pending mask clears at frame start so a runt that never reaches lookup is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else if (rise_c) begin
      pending_q <= '0;
    end else if (lookup_q) begin
      pending_q <= decision_c;
    end
  end

  always_comb begin
    dly_rise_c = dly_beat_c.dv & ~dly_dv_prev_q;
    mask_sel_c = dly_rise_c ? pending_q : active_q;
    out_mask_c = mask_sel_c & ALL_BUT;
  end

  // Active mask latches only at the delayed frame start, isolating it from later lookups
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_dv_prev_q <= 1'b0;
      active_q      <= '0;
    end else begin
      dly_dv_prev_q <= dly_beat_c.dv;
      active_q      <= mask_sel_c;
    end
  end

  // Final delay stage doubles as the per-port output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_out    <= '0;
      rx_dv_out  <= '0;
      rx_err_out <= '0;
    end else begin
      for (int p = 0; p < int'(PORT_NUMBER); p++) begin
        if (out_mask_c[p]) begin
          rxd_out[p*8 +: 8] <= dly_beat_c.data;
          rx_dv_out[p]      <= dly_beat_c.dv;
          rx_err_out[p]     <= dly_beat_c.err;
        end else begin
          rxd_out[p*8 +: 8] <= 8'h00;
          rx_dv_out[p]      <= 1'b0;
          rx_err_out[p]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_router.sv
// Directed bench for gmii_router: frames are driven byte by byte, each byte's expected
// per-port output is queued for 16 cycles later and checked against the DUT every cycle.
module tb_gmii_router;

  localparam int PN = 4;
  localparam int TD = 16;
  localparam int PW = 2;

  localparam logic [47:0] MAC_22 = 48'h02_00_00_00_00_22;
  localparam logic [47:0] MAC_55 = 48'h02_00_00_00_00_55;
  localparam logic [47:0] MAC_11 = 48'h02_00_00_00_00_11;
  localparam logic [47:0] MAC_77 = 48'h02_00_00_00_00_77;
  localparam logic [47:0] MAC_99 = 48'h02_00_00_00_00_99;
  localparam logic [47:0] MAC_MC = 48'h01_00_5e_00_00_01;
  localparam logic [47:0] MAC_BC = 48'hff_ff_ff_ff_ff_ff;

  logic              clk = 1'b0;
  logic              rst;
  logic [TD*48-1:0]  table_mac;
  logic [TD*PW-1:0]  table_port;
  logic [TD-1:0]     table_valid;
  logic [7:0]        rxd_in;
  logic              rx_dv_in;
  logic              rx_err_in;
  logic [PN*8-1:0]   rxd_out;
  logic [PN-1:0]     rx_dv_out;
  logic [PN-1:0]     rx_err_out;

  always #5 clk = ~clk;

  gmii_router #(
    .PORT_NUMBER(PN),
    .THIS_PORT_ROUTING(0),
    .TABLE_DEPTH(TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .table_mac  (table_mac),
    .table_port (table_port),
    .table_valid(table_valid),
    .rxd_in     (rxd_in),
    .rx_dv_in   (rx_dv_in),
    .rx_err_in  (rx_err_in),
    .rxd_out    (rxd_out),
    .rx_dv_out  (rx_dv_out),
    .rx_err_out (rx_err_out)
  );

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle the full output vector must equal the queued byte (or all zero)
  always @(negedge clk) begin
    if (mon_en) begin
      logic [PN*8-1:0] ed;
      logic [PN-1:0]   ev;
      logic [PN-1:0]   ee;
      exp_t            it;
      ed = '0; ev = '0; ee = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        it = exp_q.pop_front();
        for (int p = 0; p < PN; p++) begin
          if (it.mask[p]) begin
            ed[p*8 +: 8] = it.data;
            ev[p]        = 1'b1;
            ee[p]        = it.err;
          end
        end
      end
      tests++;
      assert ({rxd_out, rx_dv_out, rx_err_out} === {ed, ev, ee}) else begin
        fails++;
        $error("FAIL out_cyc%0d got=%h exp=%h", cyc, {rxd_out, rx_dv_out, rx_err_out}, {ed, ev, ee});
      end
    end
  end

  task automatic check_zero(input string tag);
    tests++;
    assert ({rxd_out, rx_dv_out, rx_err_out} === 40'h0) else begin
      fails++;
      $error("FAIL %s got=%h exp=0", tag, {rxd_out, rx_dv_out, rx_err_out});
    end
  endtask

  task automatic set_entry(input int i, input logic [47:0] mac, input logic [1:0] port, input logic v);
    table_mac[i*48 +: 48] = mac;
    table_port[i*PW +: PW] = port;
    table_valid[i]         = v;
  endtask

  // Drive one byte; expected output appears 16 cycles after the drive cycle
  task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic [3:0] m);
    rxd_in    = d;
    rx_dv_in  = dv;
    rx_err_in = er;
    if (dv) exp_q.push_back('{cyc: cyc + 16, mask: m, data: d, err: er});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic send_frame(input logic [47:0] dst, input int len, input logic [3:0] m,
                            input int err_at, input int chg_at, input int rst_at, input int gap);
    logic dead;
    logic [7:0] b;
    dead = 1'b0;
    for (int n = 0; n < len; n++) begin
      if (n < 7)       b = 8'h55;
      else if (n == 7) b = 8'hd5;
      else if (n < 14) b = dst[8*(13-n) +: 8];
      else             b = 8'($urandom);
      if (n == chg_at) set_entry(3, MAC_22, 2'd1, 1'b1);
      if (n == rst_at) begin
        rst  = 1'b0;
        exp_q.delete();
        dead = 1'b1;
        #1;
        check_zero("rst_async");
      end
      if (n == rst_at + 2) rst = 1'b1;
      drive(b, 1'b1, (n == err_at), dead ? 4'b0000 : m);
    end
    idle(gap);
  endtask

  initial begin
    rst         = 1'b1;
    table_mac   = '0;
    table_port  = '0;
    table_valid = '0;
    rxd_in      = 8'h00;
    rx_dv_in    = 1'b0;
    rx_err_in   = 1'b0;
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    set_entry(1, MAC_55, 2'd3, 1'b1);
    set_entry(3, MAC_22, 2'd2, 1'b1);
    set_entry(5, MAC_55, 2'd1, 1'b1);
    set_entry(6, MAC_11, 2'd1, 1'b1);
    set_entry(7, MAC_77, 2'd3, 1'b0);
    set_entry(8, MAC_MC, 2'd3, 1'b1);
    rst = 1'b1;
    idle(4);

    send_frame(MAC_22, 64, 4'b0100, -1, -1, -1, 3);   // unicast hit to port 2
    send_frame(MAC_BC, 64, 4'b1110, -1, -1, -1, 3);   // broadcast
    send_frame(MAC_99, 40, 4'b1110, -1, -1, -1, 3);   // unknown unicast floods
    set_entry(4, MAC_99, 2'd0, 1'b1);
    send_frame(MAC_99, 40, 4'b0000, -1, -1, -1, 3);   // hit on own port is filtered
    send_frame(MAC_55, 40, 4'b1000, -1, -1, -1, 3);   // lowest duplicate entry wins
    send_frame(MAC_11, 64, 4'b0010, -1, -1, -1, 1);   // back-to-back, 1-cycle gap
    send_frame(MAC_55, 64, 4'b1000, -1, -1, -1, 3);
    send_frame(MAC_77, 30, 4'b1110, -1, -1, -1, 3);   // invalid entry is a miss
    send_frame(MAC_MC, 30, 4'b1110, -1, -1, -1, 3);   // group bit overrides table hit
    send_frame(MAC_22, 14, 4'b0100, -1, -1, -1, 1);   // minimum length that reaches lookup
    send_frame(MAC_22, 40, 4'b0100, 20, -1, -1, 3);   // error byte forwarded
    send_frame(MAC_22, 40, 4'b0100, -1, 20, -1, 3);   // table edit after lookup ignored
    set_entry(3, MAC_22, 2'd2, 1'b1);
    send_frame(MAC_22, 10, 4'b0000, -1, -1, -1, 3);   // runt dropped
    send_frame(MAC_22, 64, 4'b0100, -1, -1, 30, 3);   // reset mid-frame, tail discarded
    send_frame(MAC_22, 40, 4'b0100, -1, -1, -1, 2);   // routing resumes after reset
    send_frame(MAC_55, 40, 4'b1000, -1, -1, -1, 2);

    idle(24);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
